nonrestoring_divider: RTL and testbench



---
 rtl/div_pkg.sv | 12 +
 rtl/div_addsub.sv | 11 +
 rtl/nonrestoring_divider.sv | 130 +++++++++++++
 tb/tb_nonrestoring_divider.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential non-restoring divider.
package div_pkg;
  localparam int DIV_WIDTH = 16;
  localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;
endpackage

// File: rtl/div_addsub.sv
// Combinational W-bit add/subtract used by the iteration and remainder fix.
module div_addsub #(
  parameter int W = 17
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic [W-1:0] o_y
);
  assign o_y = i_sub ? (i_a - i_b) : (i_a + i_b);
endmodule

// File: rtl/nonrestoring_divider.sv
// Signed/unsigned non-restoring divider, one quotient bit per clock.
module nonrestoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_n;
  logic             r_sign_q;
  logic             r_div0;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dz;

  logic             w_neg_n;
  logic             w_neg_d;
  logic             w_div0;
  logic [WIDTH-1:0] w_abs_n;
  logic [WIDTH-1:0] w_abs_d;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_as_a;
  logic [WIDTH:0]   w_as_y;
  logic             w_as_sub;
  logic [WIDTH-1:0] w_rem;

  assign w_neg_n = signed_op & dividend[WIDTH-1];
  assign w_neg_d = signed_op & divisor[WIDTH-1];
  assign w_div0  = (divisor == '0);
  assign w_abs_n = w_neg_n ? -dividend : dividend;
  assign w_abs_d = w_neg_d ? -divisor : divisor;

  // CALC feeds the shifted {A,Q}; FIX reuses the adder to restore A
  assign w_shift  = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_as_a   = (r_state == CALC) ? w_shift : r_a;
  assign w_as_sub = (r_state == CALC) & ~r_a[WIDTH];
  assign w_rem    = r_a[WIDTH] ? w_as_y[WIDTH-1:0] : r_a[WIDTH-1:0];

  div_addsub #(
    .W(WIDTH + 1)
  ) u_addsub (
    .i_a  (w_as_a),
    .i_b  ({1'b0, r_d}),
    .i_sub(w_as_sub),
    .o_y  (w_as_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = w_div0 ? FIX : CALC;
      CALC:    if (r_cnt == CNT_W'(1)) w_next = FIX;
      FIX:     w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_q      <= '0;
      r_d      <= '0;
      r_cnt    <= '0;
      r_neg_n  <= 1'b0;
      r_sign_q <= 1'b0;
      r_div0   <= 1'b0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_dz     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_a      <= '0;
            r_cnt    <= w_div0 ? '0 : CNT_W'(WIDTH);
            r_q      <= w_div0 ? dividend : w_abs_n;
            r_d      <= w_abs_d;
            r_neg_n  <= w_neg_n;
            r_sign_q <= w_neg_n ^ w_neg_d;
            r_div0   <= w_div0;
          end
        end
        CALC: begin
          r_a   <= w_as_y;
          r_q   <= {r_q[WIDTH-2:0], ~w_as_y[WIDTH]};
          r_cnt <= r_cnt - CNT_W'(1);
        end
        FIX: begin
          // divide-by-zero parks the raw dividend in Q
          r_quot <= r_div0 ? {WIDTH{DIV0_QUOTIENT[0]}}
                           : (r_sign_q ? -r_q : r_q);
          r_rem  <= r_div0 ? r_q : (r_neg_n ? -w_rem : w_rem);
          r_dz   <= r_div0;
        end
        DONE: ;
        default: ;
      endcase
    end
  end

  assign busy        = (r_state == CALC) || (r_state == FIX);
  assign done        = (r_state == DONE);
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dz;
endmodule

// File: tb/tb_nonrestoring_divider.sv
// Randomised and directed bench for nonrestoring_divider against an arithmetic model.
module tb_nonrestoring_divider;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start = 1'b0;
  logic          signed_op = 1'b0;
  logic [W-1:0]  dividend = '0;
  logic [W-1:0]  divisor = '0;
  logic          busy;
  logic          done;
  logic [W-1:0]  quotient;
  logic [W-1:0]  remainder;
  logic          div_by_zero;

  int n_chk = 0;
  int n_fail = 0;

  nonrestoring_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_op  (signed_op),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // {div_by_zero, quotient, remainder} from plain integer arithmetic
  function automatic logic [32:0] ref_div(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic s);
    int sa, sb, q, r;
    if (b == 16'h0) return {1'b1, 16'hFFFF, a};
    if (s) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
    end else begin
      sa = int'(a);
      sb = int'(b);
    end
    q = sa / sb;
    r = sa % sb;
    return {1'b0, q[15:0], r[15:0]};
  endfunction

  // Timing/result model: accepted start at edge k -> done after edge k+lat
  int          cyc = 0;
  int          m_acc = -100;
  int          m_done = -100;
  logic [32:0] m_pend = '0;
  logic [15:0] exp_q = '0;
  logic [15:0] exp_r = '0;
  logic        exp_dz = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_acc  = -100;
      m_done = -100;
      exp_q  = '0;
      exp_r  = '0;
      exp_dz = 1'b0;
    end else begin
      cyc++;
      if (cyc == m_done) begin
        exp_dz = m_pend[32];
        exp_q  = m_pend[31:16];
        exp_r  = m_pend[15:0];
      end
      if (start && (cyc - 1 > m_done)) begin
        m_acc  = cyc;
        m_done = cyc + ((divisor == '0) ? 1 : W + 1);
        m_pend = ref_div(dividend, divisor, signed_op);
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(cyc >= m_acc && cyc < m_done));
    chk("done", 32'(done), 32'(cyc == m_done));
    chk("quotient", 32'(quotient), 32'(exp_q));
    chk("remainder", 32'(remainder), 32'(exp_r));
    chk("div_by_zero", 32'(div_by_zero), 32'(exp_dz));
  end

  task automatic op(input logic [15:0] a, input logic [15:0] b,
                    input logic s, input int inj, input int rst_at,
                    output logic [15:0] q, output logic [15:0] r,
                    output logic dz, output int n, output int nb,
                    output int nd);
    @(posedge clk);
    #2;
    dividend  = a;
    divisor   = b;
    signed_op = s;
    start     = 1'b1;
    n = 0;
    nb = 0;
    nd = 0;
    while (n < 60) begin
      @(posedge clk);
      #2;
      n++;
      if (n == 1) start = 1'b0;
      if (inj != 0 && n == inj) begin
        start    = 1'b1;
        dividend = 16'd9;
        divisor  = 16'd3;
      end
      if (inj != 0 && n == inj + 1) start = 1'b0;
      if (n == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_quotient", 32'(quotient), 32'h0);
        chk("rst_remainder", 32'(remainder), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_dz", 32'(div_by_zero), 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        break;
      end
      if (busy) nb++;
      if (done) begin
        nd++;
        break;
      end
    end
    if (rst_at == 0) chk("done_seen", 32'(nd), 32'd1);
    q  = quotient;
    r  = remainder;
    dz = div_by_zero;
  endtask

  initial begin
    logic [15:0] q, r, a, b;
    logic        dz, s;
    logic [32:0] e;
    int          n, nb, nd, extra;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_q", 32'(quotient), 32'h0);
    chk("reset_r", 32'(remainder), 32'h0);
    chk("reset_busy_done", 32'({busy, done, div_by_zero}), 32'h0);
    rst = 1'b0;

    op(16'd100, 16'd7, 1'b0, 0, 0, q, r, dz, n, nb, nd);
    chk("u100/7_lat", 32'(n), 32'd18);
    chk("u100/7_busy", 32'(nb), 32'd17);
    chk("u100/7_q", 32'(q), 32'd14);
    chk("u100/7_r", 32'(r), 32'd2);
    chk("u100/7_dz", 32'(dz), 32'd0);

    op(16'hFF9C, 16'd7, 1'b1, 0, 0, q, r, dz, n, nb, nd);
    chk("s-100/7_q", 32'(q), 32'hFFF2);
    chk("s-100/7_r", 32'(r), 32'hFFFE);
    op(16'd100, 16'hFFF9, 1'b1, 0, 0, q, r, dz, n, nb, nd);
    chk("s100/-7_q", 32'(q), 32'hFFF2);
    chk("s100/-7_r", 32'(r), 32'h0002);

    op(16'h8000, 16'hFFFF, 1'b1, 0, 0, q, r, dz, n, nb, nd);
    chk("ovf_q", 32'(q), 32'h8000);
    chk("ovf_r", 32'(r), 32'h0);
    op(16'hFFFF, 16'd1, 1'b0, 0, 0, q, r, dz, n, nb, nd);
    chk("uFFFF/1_q", 32'(q), 32'hFFFF);
    chk("uFFFF/1_r", 32'(r), 32'h0);
    op(16'd5, 16'd9, 1'b0, 0, 0, q, r, dz, n, nb, nd);
    chk("u5/9_q", 32'(q), 32'h0);
    chk("u5/9_r", 32'(r), 32'd5);

    op(16'd1234, 16'd0, 1'b0, 0, 0, q, r, dz, n, nb, nd);
    chk("div0_lat", 32'(n), 32'd2);
    chk("div0_q", 32'(q), 32'hFFFF);
    chk("div0_r", 32'(r), 32'd1234);
    chk("div0_flag", 32'(dz), 32'd1);
    op(16'd50, 16'd5, 1'b0, 0, 0, q, r, dz, n, nb, nd);
    chk("div0_clear", 32'(dz), 32'd0);
    chk("u50/5_q", 32'(q), 32'd10);

    op(16'd60, 16'd4, 1'b0, 5, 0, q, r, dz, n, nb, nd);
    chk("proto_q", 32'(q), 32'd15);
    chk("proto_r", 32'(r), 32'd0);
    chk("proto_lat", 32'(n), 32'd18);
    extra = 0;
    repeat (6) begin
      @(posedge clk);
      #2;
      if (done) extra++;
    end
    chk("proto_single_done", 32'(extra), 32'd0);
    chk("proto_hold_q", 32'(quotient), 32'd15);

    op(16'd300, 16'd11, 1'b0, 0, 8, q, r, dz, n, nb, nd);
    op(16'd300, 16'd11, 1'b0, 0, 0, q, r, dz, n, nb, nd);
    chk("post_rst_q", 32'(q), 32'd27);
    chk("post_rst_r", 32'(r), 32'd3);

    for (int i = 0; i < 150; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      s = 1'($urandom);
      case ($urandom_range(0, 9))
        0: b = 16'h0;
        1: b = 16'h1;
        2: b = 16'hFFFF;
        3: a = 16'h8000;
        4: b = 16'($urandom_range(1, 15));
        default: ;
      endcase
      op(a, b, s, 0, 0, q, r, dz, n, nb, nd);
      e = ref_div(a, b, s);
      chk("rand_result", 32'({dz, q, r}), 32'(e[32:1]) << 1 | 32'(e[0]));
      chk("rand_lat", 32'(n), (b == 16'h0) ? 32'd2 : 32'd18);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
